vend_ctrl_param: RTL and testbench
==================================

// Module: vend_ctrl_param
// PURPOSE
//  Parametrised vending controller: accepts nickel/dime/quarter coins, holds credit and
//  vends one of NUM_PROD products at per-product prices. Returns change as a timed
//  sequence of coin-dispense pulses.
//  Sits between the debounced board buttons/switches and the 7-seg/LED display drivers.
// PARAMETERS
//  NUM_PROD    4                              number of products (one-hot select width)
//  CREDIT_W    8                              width of credit, price and change values
//  PRICES      {8'd30,8'd25,8'd20,8'd15}      packed, CREDIT_W bits/entry; entry i = product i
//  MAX_CREDIT  95                             coins pushing credit above this are rejected
//  VAL_N/D/Q   5/10/25                        coin values; all prices, MAX_CREDIT multiples of VAL_N
//  VEND_CYC    4                              cycles vend_led is held
// PORTS
//  clk        in   1         clock
//  clr        in   1         async active-high reset
//  coin_in    in   3         level, bit0 nickel, bit1 dime, bit2 quarter; rising edge = insert
//  sel        in   NUM_PROD  level, one-hot product select
//  cancel     in   1         level; request refund of credit
//  credit     out  CREDIT_W  registered current credit
//  price_disp out  CREDIT_W  registered price of sel product; 0 if sel not one-hot
//  vend_led   out  NUM_PROD  one-hot product being vended
//  coin_out   out  3         one-cycle change pulses, same bit map as coin_in
//  busy       out  1         high in VEND or CHANGE
//  reject     out  1         one-cycle pulse: coin refused
// BEHAVIOUR
//  Reset (async on clr):
//   - all outputs 0; state COLLECT; credit 0
//   - coin edge-detect register set to 3'b111, so a coin held through reset is not counted
//   - clr mid-VEND/CHANGE aborts the operation; remaining credit is discarded
//  Coin event:
//   - a bit of coin_in rising versus its previous-cycle value
//   - more than one bit rising in the same cycle -> reject, credit unchanged
//  States:
//   - COLLECT (credit accumulates)
//   - VEND (vend_led held)
//   - CHANGE (one coin pulse per cycle)
//  COLLECT priority, per cycle: cancel > valid sel > coin.
//   - cancel && credit>0 -> CHANGE; cancel && credit==0 -> no effect
//   - sel one-hot && credit >= PRICES[i]:
//       credit <= credit - PRICES[i]; vend_led <= sel; -> VEND
//       a coin event in the same cycle is rejected
//   - sel one-hot && credit < price: stay; price_disp shows price
//   - coin event: credit+val <= MAX_CREDIT -> credit += val (visible next cycle); else reject
//  VEND:
//   - vend_led held exactly VEND_CYC cycles, then cleared
//   - then -> CHANGE if credit>0, else COLLECT
//   - coin events rejected; sel and cancel ignored
//  CHANGE, each cycle:
//   - pulse the largest coin with value <= credit, greedy Q>D>N; credit -= value
//   - when credit reaches 0 -> COLLECT on the following cycle (no pulse that cycle)
//   - coins rejected; cancel and sel ignored
//  price_disp: updated every cycle in every state, 1-cycle latency from sel.
//  Arithmetic:
//   - credit unsigned CREDIT_W bits
//   - add compared against MAX_CREDIT in CREDIT_W+1 bits, so there is no wrap
//   - MAX_CREDIT < 2**CREDIT_W
// TESTING
//  1. reset; Q,Q edges; sel=4'b0001 -> credit 25 then 50; vend_led=0001 for 4 cycles;
//     coin_out Q, D, then credit 0, state COLLECT.
//  2. credit 10; sel=4'b1000 -> price_disp 30 next cycle, no vend, credit stays 10.
//  3. credit 85; Q inserted -> reject pulse, credit 85; N inserted -> credit 90.
//  4. credit 40; cancel -> coin_out Q, D, N on three consecutive cycles, busy high throughout,
//     credit 0 after.
//  5. credit 20; sel=4'b0010 and D edge in same cycle -> vend, credit 0, reject pulse;
//     coin_in=3'b011 rising together -> reject.
//  6. clr asserted mid-CHANGE (credit 15) -> all outputs 0 immediately;
//     coin held high across reset is not counted.

Source files
------------

// File: rtl/vend_ctrl_param.sv
// ---------------------------------------------------------------------------
// vend_ctrl_param
//   Parametrised vending controller. Accepts nickel/dime/quarter coins,
//   accumulates credit, vends one of NUM_PROD products at per-product prices
//   and pays change back as a sequence of one-cycle coin pulses.
//
// Ports
//   clk         clock
//   clr         asynchronous active-high reset
//   coin_in     [2:0] coin levels (bit0 N, bit1 D, bit2 Q); a rising edge inserts
//   sel         [NUM_PROD-1:0] one-hot product select (level)
//   cancel      refund request (level)
//   credit      [CREDIT_W-1:0] registered current credit
//   price_disp  [CREDIT_W-1:0] registered price of the selected product, 0 if
//               sel is not one-hot
//   vend_led    [NUM_PROD-1:0] one-hot product being vended
//   coin_out    [2:0] one-cycle change pulses, same bit map as coin_in
//   busy        high while vending or paying change
//   reject      one-cycle pulse when a coin is refused
// ---------------------------------------------------------------------------
module vend_ctrl_param #(
    parameter int                            NUM_PROD   = 4,
    parameter int                            CREDIT_W   = 8,
    parameter logic [NUM_PROD*CREDIT_W-1:0]  PRICES     = {8'd30, 8'd25, 8'd20, 8'd15},
    parameter int                            MAX_CREDIT = 95,
    parameter int                            VAL_N      = 5,
    parameter int                            VAL_D      = 10,
    parameter int                            VAL_Q      = 25,
    parameter int                            VEND_CYC   = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [2:0]          coin_in,
    input  logic [NUM_PROD-1:0] sel,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] price_disp,
    output logic [NUM_PROD-1:0] vend_led,
    output logic [2:0]          coin_out,
    output logic                busy,
    output logic                reject
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam int CNT_W = (VEND_CYC > 1) ? $clog2(VEND_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEND_CYC - 1);

    // Wide forms for the overflow-free add-and-compare, narrow forms for change.
    localparam logic [CREDIT_W:0]   MAX_X = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   VN_X  = (CREDIT_W+1)'(VAL_N);
    localparam logic [CREDIT_W:0]   VD_X  = (CREDIT_W+1)'(VAL_D);
    localparam logic [CREDIT_W:0]   VQ_X  = (CREDIT_W+1)'(VAL_Q);
    localparam logic [CREDIT_W-1:0] VN_C  = CREDIT_W'(VAL_N);
    localparam logic [CREDIT_W-1:0] VD_C  = CREDIT_W'(VAL_D);
    localparam logic [CREDIT_W-1:0] VQ_C  = CREDIT_W'(VAL_Q);

    state_t              state, state_nxt;
    logic [2:0]          coin_prev;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [CREDIT_W-1:0] credit_nxt, price_nxt, sel_price;
    logic [NUM_PROD-1:0] vend_led_nxt;
    logic [2:0]          coin_out_nxt, coin_rise;
    logic                reject_nxt, sel_ok, coin_event, coin_multi;
    logic [CREDIT_W:0]   coin_val, credit_sum;

    assign busy = (state != COLLECT);

    // Price lookup and coin decode.
    // NOTE: every variable assigned in an always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        sel_price = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (sel[i]) sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
        end
        sel_ok     = $onehot(sel);
        coin_rise  = coin_in & ~coin_prev;
        coin_event = |coin_rise;
        coin_multi = coin_event && !$onehot(coin_rise);
        coin_val   = '0;
        case (coin_rise)
            3'b001:  coin_val = VN_X;
            3'b010:  coin_val = VD_X;
            3'b100:  coin_val = VQ_X;
            default: coin_val = '0;
        endcase
        credit_sum = {1'b0, credit} + coin_val;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit;
        vend_led_nxt = vend_led;
        cnt_nxt      = cnt;
        coin_out_nxt = '0;
        reject_nxt   = 1'b0;
        price_nxt    = sel_ok ? sel_price : '0;

        case (state)
            COLLECT: begin
                if (cancel && credit != '0) begin
                    state_nxt  = CHANGE;
                    reject_nxt = coin_event;
                end else if (sel_ok && credit >= sel_price) begin
                    credit_nxt   = credit - sel_price;
                    vend_led_nxt = sel;
                    cnt_nxt      = '0;
                    state_nxt    = VEND;
                    reject_nxt   = coin_event;
                end else if (coin_event) begin
                    if (coin_multi || credit_sum > MAX_X) begin
                        reject_nxt = 1'b1;
                    end else begin
                        credit_nxt = credit_sum[CREDIT_W-1:0];
                    end
                end
            end

            VEND: begin
                reject_nxt = coin_event;
                if (cnt == CNT_LAST) begin
                    vend_led_nxt = '0;
                    state_nxt    = (credit != '0) ? CHANGE : COLLECT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            CHANGE: begin
                reject_nxt = coin_event;
                if (credit >= VQ_C) begin
                    coin_out_nxt = 3'b100;
                    credit_nxt   = credit - VQ_C;
                end else if (credit >= VD_C) begin
                    coin_out_nxt = 3'b010;
                    credit_nxt   = credit - VD_C;
                end else if (credit >= VN_C) begin
                    coin_out_nxt = 3'b001;
                    credit_nxt   = credit - VN_C;
                end else begin
                    // Nothing left that a coin can pay out.
                    state_nxt = COLLECT;
                end
            end

            default: state_nxt = COLLECT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= COLLECT;
            credit     <= '0;
            price_disp <= '0;
            vend_led   <= '0;
            coin_out   <= '0;
            reject     <= 1'b0;
            cnt        <= '0;
            // All ones: a coin already high when reset releases is not an edge.
            coin_prev  <= 3'b111;
        end else begin
            state      <= state_nxt;
            credit     <= credit_nxt;
            price_disp <= price_nxt;
            vend_led   <= vend_led_nxt;
            coin_out   <= coin_out_nxt;
            reject     <= reject_nxt;
            cnt        <= cnt_nxt;
            coin_prev  <= coin_in;
        end
    end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_vend_ctrl_param
//   Directed bench for vend_ctrl_param with default parameters
//   (prices: sel bit0=15, bit1=20, bit2=25, bit3=30; max credit 95).
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vend_ctrl_param;

    logic       clk = 1'b0;
    logic       clr;
    logic [2:0] coin_in;
    logic [3:0] sel;
    logic       cancel;
    logic [7:0] credit, price_disp;
    logic [3:0] vend_led;
    logic [2:0] coin_out;
    logic       busy, reject;

    int total = 0;
    int bad   = 0;

    vend_ctrl_param dut (
        .clk        (clk),
        .clr        (clr),
        .coin_in    (coin_in),
        .sel        (sel),
        .cancel     (cancel),
        .credit     (credit),
        .price_disp (price_disp),
        .vend_led   (vend_led),
        .coin_out   (coin_out),
        .busy       (busy),
        .reject     (reject)
    );

    always #5 clk = ~clk;

    // Insert one coin pattern for one cycle; returns on the falling edge where
    // the resulting credit/reject is visible.
    task automatic insert(input logic [2:0] c);
        @(negedge clk); coin_in = c;
        @(negedge clk); coin_in = 3'b000;
    endtask

    // Refund all credit and wait (bounded) for the controller to go idle.
    task automatic drain();
        int n;
        @(negedge clk); cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        n = 0;
        while (busy && n < 30) begin @(negedge clk); n++; end
        total++;
        if (busy !== 1'b0 || credit !== 8'd0) begin
            bad++; $display("FAIL drain busy=%b credit=%0d exp busy=0 credit=0", busy, credit);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; coin_in = 3'b000; sel = '0; cancel = 1'b0;
        #12;
        total++;
        if ({credit, price_disp, vend_led, coin_out, busy, reject} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0",
                            {credit, price_disp, vend_led, coin_out, busy, reject});
        end
        @(negedge clk); clr = 1'b0;
        @(negedge clk);
        total++;
        if (credit !== 8'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle credit=%0d busy=%b exp 0/0", credit, busy);
        end
    endtask

    task automatic test_vend_change();
        int vend_cnt, n;
        logic [2:0] coins[$];
        insert(3'b100);
        total++;
        if (credit !== 8'd25) begin bad++; $display("FAIL t1_credit25 got=%0d exp=25", credit); end
        insert(3'b100);
        total++;
        if (credit !== 8'd50) begin bad++; $display("FAIL t1_credit50 got=%0d exp=50", credit); end
        @(negedge clk); sel = 4'b0001;
        @(negedge clk); sel = 4'b0000;
        total++;
        if (vend_led !== 4'b0001 || credit !== 8'd35 || busy !== 1'b1 || price_disp !== 8'd15) begin
            bad++; $display("FAIL t1_vend led=%b credit=%0d busy=%b price=%0d exp 0001/35/1/15",
                            vend_led, credit, busy, price_disp);
        end
        vend_cnt = 1; n = 0;
        while (busy && n < 20) begin
            @(negedge clk); n++;
            if (vend_led === 4'b0001) vend_cnt++;
            if (coin_out !== 3'b000) coins.push_back(coin_out);
        end
        total++;
        if (busy !== 1'b0 || vend_cnt != 4) begin
            bad++; $display("FAIL t1_vend_len busy=%b cycles=%0d exp busy=0 cycles=4", busy, vend_cnt);
        end
        total++;
        if (coins.size() != 2 || coins[0] !== 3'b100 || coins[1] !== 3'b010 || credit !== 8'd0) begin
            bad++; $display("FAIL t1_change n=%0d credit=%0d exp Q,D credit 0", coins.size(), credit);
        end
    endtask

    task automatic test_price_low();
        insert(3'b010);
        @(negedge clk); sel = 4'b1000;
        @(negedge clk);
        total++;
        if (price_disp !== 8'd30 || credit !== 8'd10 || vend_led !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL t2_price price=%0d credit=%0d led=%b busy=%b exp 30/10/0000/0",
                            price_disp, credit, vend_led, busy);
        end
        sel = 4'b0000;
        @(negedge clk);
        total++;
        if (price_disp !== 8'd0) begin bad++; $display("FAIL t2_price_clear got=%0d exp=0", price_disp); end
    endtask

    task automatic test_max_credit();
        insert(3'b100); insert(3'b100); insert(3'b100);
        total++;
        if (credit !== 8'd85) begin bad++; $display("FAIL t3_credit85 got=%0d exp=85", credit); end
        insert(3'b100);
        total++;
        if (reject !== 1'b1 || credit !== 8'd85) begin
            bad++; $display("FAIL t3_reject reject=%b credit=%0d exp 1/85", reject, credit);
        end
        @(negedge clk);
        total++;
        if (reject !== 1'b0) begin bad++; $display("FAIL t3_reject_pulse got=%b exp=0", reject); end
        insert(3'b001);
        total++;
        if (credit !== 8'd90 || reject !== 1'b0) begin
            bad++; $display("FAIL t3_credit90 credit=%0d reject=%b exp 90/0", credit, reject);
        end
        drain();
    endtask

    task automatic test_cancel();
        logic [2:0] exp_coin[3];
        logic [7:0] exp_cred[3];
        exp_coin = '{3'b100, 3'b010, 3'b001};
        exp_cred = '{8'd15, 8'd5, 8'd0};
        insert(3'b100); insert(3'b010); insert(3'b001);
        total++;
        if (credit !== 8'd40) begin bad++; $display("FAIL t4_credit40 got=%0d exp=40", credit); end
        @(negedge clk); cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        total++;
        if (busy !== 1'b1 || coin_out !== 3'b000) begin
            bad++; $display("FAIL t4_enter busy=%b coin=%b exp 1/000", busy, coin_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (coin_out !== exp_coin[i] || credit !== exp_cred[i] || busy !== 1'b1) begin
                bad++; $display("FAIL t4_pulse%0d coin=%b credit=%0d busy=%b exp %b/%0d/1",
                                i, coin_out, credit, busy, exp_coin[i], exp_cred[i]);
            end
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || coin_out !== 3'b000 || credit !== 8'd0) begin
            bad++; $display("FAIL t4_done busy=%b coin=%b credit=%0d exp 0/000/0", busy, coin_out, credit);
        end
    endtask

    task automatic test_back_to_back();
        int n, pulses;
        insert(3'b010); insert(3'b010);
        @(negedge clk); sel = 4'b0010; coin_in = 3'b010;
        @(negedge clk); sel = 4'b0000; coin_in = 3'b000;
        total++;
        if (vend_led !== 4'b0010 || credit !== 8'd0 || reject !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL t5_vend led=%b credit=%0d reject=%b busy=%b exp 0010/0/1/1",
                            vend_led, credit, reject, busy);
        end
        n = 0; pulses = 0;
        while (busy && n < 20) begin
            @(negedge clk); n++;
            if (coin_out !== 3'b000) pulses++;
        end
        total++;
        if (busy !== 1'b0 || pulses != 0 || n != 4) begin
            bad++; $display("FAIL t5_no_change busy=%b pulses=%0d cycles=%0d exp 0/0/4", busy, pulses, n);
        end
        insert(3'b011);
        total++;
        if (reject !== 1'b1 || credit !== 8'd0) begin
            bad++; $display("FAIL t5_multi reject=%b credit=%0d exp 1/0", reject, credit);
        end
    endtask

    task automatic test_reset_mid_change();
        insert(3'b100); insert(3'b010); insert(3'b001);
        @(negedge clk); cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        @(negedge clk);
        total++;
        if (credit !== 8'd15 || coin_out !== 3'b100) begin
            bad++; $display("FAIL t6_pre credit=%0d coin=%b exp 15/100", credit, coin_out);
        end
        #2; coin_in = 3'b001; clr = 1'b1;
        #1;
        total++;
        if ({credit, price_disp, vend_led, coin_out, busy, reject} !== '0) begin
            bad++; $display("FAIL t6_async_clr got=%h exp=0",
                            {credit, price_disp, vend_led, coin_out, busy, reject});
        end
        @(negedge clk); clr = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (credit !== 8'd0 || reject !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL t6_held_coin credit=%0d reject=%b busy=%b exp 0/0/0", credit, reject, busy);
        end
        coin_in = 3'b000;
        insert(3'b001);
        total++;
        if (credit !== 8'd5) begin bad++; $display("FAIL t6_after credit=%0d exp=5", credit); end
    endtask

    initial begin
        test_reset();
        test_vend_change();
        test_price_low();
        test_max_credit();
        test_cancel();
        test_back_to_back();
        test_reset_mid_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
